// File: rtl/ext_bus_pkg.sv
// Shared offsets and bit positions for the external bus responder register map.
package ext_bus_pkg;

  localparam logic [31:0] OFF_FIFO_DATA = 32'h10;
  localparam logic [31:0] OFF_STATUS    = 32'h11;
  localparam logic [31:0] OFF_CTRL      = 32'h12;
  localparam logic [31:0] OFF_TIMER     = 32'h13;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_FLUSH   = 1;

  function automatic logic [31:0] status_word(input logic [7:0] cnt, input logic ovf,
                                              input logic full, input logic empty);
    logic [31:0] w;
    w = '0;
    w[ST_CNT_LSB +: 8] = cnt;
    w[ST_OVF]          = ovf;
    w[ST_FULL]         = full;
    w[ST_EMPTY]        = empty;
    return w;
  endfunction

endpackage

// File: rtl/tx_sync_fifo.sv
// Single-clock FIFO with flush; head word is presented combinationally (zero when empty).
module tx_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic [WIDTH-1:0]           head
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a word when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ext_bus_responder.sv
// Off-chip CPU bus target: scratch RAM, TX FIFO, STATUS/CTRL and a free-running timer.
module ext_bus_responder
  import ext_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR     = 32'h0000_2000,
  parameter int          SCRATCH_WORDS = 16,
  parameter int          FIFO_DEPTH    = 8
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        CS,
  input  logic        WE,
  input  logic [31:0] ADDR,
  input  logic [31:0] Data_BUS_WRITE,
  output logic [31:0] Data_BUS_READ,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int SW = $clog2(SCRATCH_WORDS);

  logic [31:0]   off;
  logic          hit;
  logic          wr_hit;
  logic          scratch_sel;
  logic          fifo_push;
  logic          ctrl_wr;
  logic          flush;
  logic          clr_ovf;
  logic          pop;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic          ovf;
  logic [31:0]   timer;
  logic [31:0]   rd_mux;
  logic [31:0]   scratch [SCRATCH_WORDS];

  assign off         = ADDR - BASE_ADDR;
  assign hit         = CS && (ADDR >= BASE_ADDR) && (off <= OFF_TIMER);
  assign wr_hit      = hit && WE;
  assign scratch_sel = (off < 32'(SCRATCH_WORDS));
  assign fifo_push   = wr_hit && (off == OFF_FIFO_DATA);
  assign ctrl_wr     = wr_hit && (off == OFF_CTRL);
  assign flush       = ctrl_wr && Data_BUS_WRITE[CTRL_FLUSH];
  assign clr_ovf     = ctrl_wr && Data_BUS_WRITE[CTRL_CLR_OVF];
  assign out_valid   = !empty;
  assign pop         = out_valid && out_ready;

  tx_sync_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (CLK),
    .rst_n     (Reset),
    .push      (fifo_push),
    .push_data (Data_BUS_WRITE),
    .pop       (pop),
    .flush     (flush),
    .full      (full),
    .empty     (empty),
    .count     (count),
    .head      (out_data)
  );

  always_comb begin
    rd_mux = '0;
    if (hit) begin
      if (scratch_sel)
        rd_mux = scratch[off[SW-1:0]];
      else if (off == OFF_STATUS)
        rd_mux = status_word({{(8-CW){1'b0}}, count}, ovf, full, empty);
      else if (off == OFF_TIMER)
        rd_mux = timer;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ovf           <= 1'b0;
      timer         <= '0;
      Data_BUS_READ <= '0;
    end else begin
      // A dropped push outranks a same-cycle clear; flush suppresses the drop entirely.
      if (fifo_push && full && !pop && !flush)
        ovf <= 1'b1;
      else if (clr_ovf)
        ovf <= 1'b0;
      timer <= (wr_hit && (off == OFF_TIMER)) ? Data_BUS_WRITE : timer + 32'd1;
      if (CS && !WE)
        Data_BUS_READ <= rd_mux;
    end
  end

  always_ff @(posedge CLK) begin
    if (wr_hit && scratch_sel) scratch[off[SW-1:0]] <= Data_BUS_WRITE;
  end

endmodule

// File: tb/tb_ext_bus_responder.sv
// Randomized scoreboard bench for ext_bus_responder against a queue-based reference model.
module tb_ext_bus_responder;

  localparam logic [31:0] BASE  = 32'h0000_2000;
  localparam int          DEPTH = 8;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        CS = 1'b0;
  logic        WE = 1'b0;
  logic [31:0] ADDR = '0;
  logic [31:0] Data_BUS_WRITE = '0;
  logic        out_ready = 1'b0;
  logic [31:0] Data_BUS_READ;
  logic        out_valid;
  logic [31:0] out_data;

  always #5 CLK = ~CLK;

  ext_bus_responder #(
    .BASE_ADDR     (BASE),
    .SCRATCH_WORDS (16),
    .FIFO_DEPTH    (DEPTH)
  ) dut (
    .CLK            (CLK),
    .Reset          (Reset),
    .CS             (CS),
    .WE             (WE),
    .ADDR           (ADDR),
    .Data_BUS_WRITE (Data_BUS_WRITE),
    .Data_BUS_READ  (Data_BUS_READ),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data)
  );

  int checks = 0;
  int fails  = 0;

  logic [31:0] exp_rd[$];
  logic [31:0] exp_out[$];
  logic [31:0] m_scr [16];
  int          m_cnt;
  bit          m_ovf;
  logic [31:0] m_timer;
  logic [31:0] last_rd = '0;
  bit          rd_flag = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK or negedge Reset) begin
    if (!Reset) rd_flag <= 1'b0;
    else        rd_flag <= CS && !WE;
  end

  // Monitor: read data one clock after each read, hold otherwise, and the TX drain stream.
  always @(negedge CLK) begin
    if (!Reset) begin
      exp_rd.delete();
      last_rd = '0;
      check("reset_read_data", Data_BUS_READ, 32'h0);
      check("reset_out_valid", 32'(out_valid), 32'h0);
    end else begin
      if (rd_flag) begin
        if (exp_rd.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL read_data: got %h expected nothing (no read pending)", Data_BUS_READ);
        end else begin
          last_rd = exp_rd.pop_front();
          check("read_data", Data_BUS_READ, last_rd);
        end
      end else begin
        check("read_hold", Data_BUS_READ, last_rd);
      end
      if (out_valid && out_ready) begin
        if (exp_out.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL drain_word: got %h expected no word", out_data);
        end else begin
          check("drain_word", out_data, exp_out.pop_front());
        end
      end
    end
  end

  task automatic do_reset(input int n);
    Reset = 1'b0;
    CS = 1'b0;
    WE = 1'b0;
    out_ready = 1'b0;
    exp_out.delete();
    m_cnt = 0;
    m_ovf = 1'b0;
    m_timer = '0;
    repeat (n) @(posedge CLK);
    #1;
    Reset = 1'b1;
  endtask

  // One bus cycle: apply inputs, advance the model across the coming edge, then check FIFO flags.
  task automatic drive(input bit cs, input bit we, input logic [31:0] addr,
                       input logic [31:0] wd, input bit rdy_in);
    logic [31:0] off = addr - BASE;
    bit          hit = cs && (addr >= BASE) && (off <= 32'h13);
    bit          wr = hit && we;
    bit          flush = wr && (off == 32'h12) && wd[1];
    bit          clr = wr && (off == 32'h12) && wd[0];
    bit          push = wr && (off == 32'h10);
    bit          rdy = flush ? 1'b0 : rdy_in;
    bit          pop = rdy && (m_cnt > 0);
    bit          set_ovf = 1'b0;
    logic [31:0] rv = '0;
    logic [31:0] tnext;
    if (cs && !we) begin
      if (hit && off < 32'd16)
        rv = m_scr[off[3:0]];
      else if (hit && off == 32'h11)
        rv = 32'(m_cnt) * 256 + (m_ovf ? 32'd4 : 32'd0)
           + ((m_cnt == DEPTH) ? 32'd2 : 32'd0) + ((m_cnt == 0) ? 32'd1 : 32'd0);
      else if (hit && off == 32'h13)
        rv = m_timer;
      exp_rd.push_back(rv);
    end
    if (flush) begin
      exp_out.delete();
      m_cnt = 0;
    end else begin
      if (push) begin
        if (m_cnt < DEPTH || pop) begin
          exp_out.push_back(wd);
          m_cnt++;
        end else begin
          set_ovf = 1'b1;
        end
      end
      if (pop) m_cnt--;
    end
    m_ovf = set_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
    if (wr && off < 32'd16) m_scr[off[3:0]] = wd;
    tnext = (wr && off == 32'h13) ? wd : m_timer + 32'd1;
    CS = cs;
    WE = we;
    ADDR = addr;
    Data_BUS_WRITE = wd;
    out_ready = rdy;
    @(posedge CLK);
    #1;
    m_timer = tnext;
    check("out_valid", 32'(out_valid), 32'(m_cnt > 0));
    if (m_cnt == 0) check("out_data_empty", out_data, 32'h0);
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 32'h0, 32'h0, rdy);
  endtask

  task automatic rd(input logic [31:0] off);
    drive(1'b1, 1'b0, BASE + off, 32'h0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d, input bit rdy);
    drive(1'b1, 1'b1, BASE + off, d, rdy);
  endtask

  task automatic init_scratch();
    for (int i = 0; i < 16; i++) wr(32'(i), $urandom, 1'b0);
  endtask

  int          k;
  bit          rdy_r;
  logic [31:0] ua;

  initial begin
    do_reset(3);
    // Reset state, STATUS, timer count-up
    rd(32'h11);
    idle(3, 1'b0);
    rd(32'h13);
    init_scratch();

    // Scratch round trip and unmapped reads
    wr(32'h3, 32'hCAFE_0001, 1'b0);
    rd(32'h3);
    drive(1'b1, 1'b0, BASE + 32'h20, 32'h0, 1'b0);
    drive(1'b1, 1'b0, BASE - 32'h1, 32'h0, 1'b0);
    drive(1'b1, 1'b1, BASE + 32'h14, 32'h1234_5678, 1'b0);
    wr(32'h11, 32'hFFFF_FFFF, 1'b0);
    rd(32'h11);
    rd(32'h10);
    rd(32'h12);

    // Overflow on the ninth push, then drain 1..8
    for (int i = 1; i <= 9; i++) wr(32'h10, 32'(i), 1'b0);
    rd(32'h11);
    idle(10, 1'b1);
    rd(32'h11);

    // Full FIFO with a simultaneous pop and push
    wr(32'h12, 32'h1, 1'b0);
    for (int i = 0; i < DEPTH; i++) wr(32'h10, 32'h100 + 32'(i), 1'b0);
    wr(32'h10, 32'h1FF, 1'b1);
    rd(32'h11);

    // Clear overflow + flush together, timer wrap
    wr(32'h10, 32'hDEAD, 1'b0);
    rd(32'h11);
    wr(32'h12, 32'h3, 1'b0);
    rd(32'h11);
    wr(32'h13, 32'hFFFF_FFFE, 1'b0);
    rd(32'h13);
    rd(32'h13);
    rd(32'h13);

    // Reset between a read and its data edge
    wr(32'h10, 32'h55, 1'b0);
    wr(32'h10, 32'h66, 1'b0);
    rd(32'h3);
    do_reset(1);
    rd(32'h11);
    rd(32'h13);
    init_scratch();

    // Randomized traffic
    for (int n = 0; n < 500; n++) begin
      k = int'($urandom_range(0, 10));
      rdy_r = ($urandom_range(0, 3) != 0);
      case (k)
        0, 1: wr(32'($urandom_range(0, 15)), $urandom, rdy_r);
        2, 3: drive(1'b1, 1'b0, BASE + 32'($urandom_range(0, 19)), 32'h0, rdy_r);
        4, 5: wr(32'h10, $urandom, rdy_r);
        6:    wr(32'h12, 32'($urandom_range(0, 3)), rdy_r);
        7:    wr(32'h13, $urandom, rdy_r);
        8: begin
          ua = ($urandom_range(0, 1) != 0) ? BASE + 32'h14 + 32'($urandom_range(0, 100))
                                           : BASE - 32'h1 - 32'($urandom_range(0, 100));
          drive(1'b1, 1'($urandom_range(0, 1)), ua, $urandom, rdy_r);
        end
        9:  wr(32'h11, $urandom, rdy_r);
        default: drive(1'b0, 1'($urandom_range(0, 1)), BASE + 32'($urandom_range(0, 19)),
                       $urandom, rdy_r);
      endcase
    end

    idle(DEPTH + 2, 1'b1);
    rd(32'h11);
    idle(2, 1'b0);
    check("scoreboard_empty", 32'(exp_out.size()), 32'h0);
    check("reads_consumed", 32'(exp_rd.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
